// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg
// Shared constants for the 6502 interrupt sequencer. The microcode decoder
// and the vector address mux use the same vector-select and step encodings.
//   seq_state_e      : sequencer state (IDLE / SEQ_RESET / SEQ_NMI / SEQ_IRQ)
//   VECTOR_SEL_*     : vector select codes driven on o_vector_sel
//   TCU_FETCH        : microcode step value meaning "next cycle is an opcode fetch"
package interrupt_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEQ_RESET = 2'd1,
      ST_SEQ_NMI   = 2'd2,
      ST_SEQ_IRQ   = 2'd3
   } seq_state_e;

   localparam logic [1:0] VECTOR_SEL_IRQ   = 2'b00;  // FFFE (IRQ / BRK)
   localparam logic [1:0] VECTOR_SEL_NMI   = 2'b01;  // FFFA
   localparam logic [1:0] VECTOR_SEL_RESET = 2'b10;  // FFFC

   localparam logic [3:0] TCU_FETCH = 4'd1;

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// interrupt_sequencer_nmi_edge_detect
// Falling-edge detector and pending latch for the NMI line.
//   clk_i      in  : CPU clock, state updates on negedge
//   reset_n_i  in  : asynchronous active-low reset
//   nmi_n_i    in  : raw NMI request (active low)
//   clear_i    in  : NMI serviced this edge
//   pending_o  out : edge latched and not yet serviced
module interrupt_sequencer_nmi_edge_detect (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic nmi_n_i,
   input  logic clear_i,
   output logic pending_o
);

   logic prev_q;
   logic pending_q;
   logic armed_q;
   logic set_edge;
   logic pending_d;

   // armed_q suppresses detection on the first edge after reset, so a line
   // that was already low while reset was asserted is not seen as a new edge.
   assign set_edge  = armed_q & prev_q & ~nmi_n_i;
   // A new edge on the same clock as a service keeps the request pending.
   assign pending_d = set_edge | (pending_q & ~clear_i);

   always_ff @(negedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         prev_q    <= 1'b1;
         pending_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         prev_q    <= nmi_n_i;
         pending_q <= pending_d;
         armed_q   <= 1'b1;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Sequences reset, NMI and IRQ entry for the 6502 core. Tells the instruction
// register when to hold BRK at a poll point and selects the interrupt vector.
//   i_clk          in  : CPU clock, state updates on negedge (end of phi2)
//   i_reset_n      in  : asynchronous active-low reset
//   i_nmi_n        in  : NMI request, falling-edge sensitive
//   i_irq_n        in  : IRQ request, level-sensitive, active low
//   i_flag_i       in  : status I flag (IRQ disable)
//   i_tcu_next     in  : next microcode step; TCU_FETCH marks a poll point
//   i_vector_cycle in  : cycle before the vector low-byte read (commit point)
//   o_force_brk    out : IR must hold BRK at this poll point
//   o_int_active   out : hardware sequence in progress
//   o_reset_active out : reset sequence in progress
//   o_vector_sel   out : 00 = FFFE, 01 = FFFA, 10 = FFFC
//   o_nmi_pending  out : NMI edge latched, not yet serviced
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_nmi_n,
   input  logic       i_irq_n,
   input  logic       i_flag_i,
   input  logic [3:0] i_tcu_next,
   input  logic       i_vector_cycle,
   output logic       o_force_brk,
   output logic       o_int_active,
   output logic       o_reset_active,
   output logic [1:0] o_vector_sel,
   output logic       o_nmi_pending
);

   seq_state_e state_q;
   seq_state_e state_d;
   logic [1:0] vector_q;
   logic [1:0] vector_d;
   logic       int_active_q;
   logic       int_active_d;
   logic       reset_active_q;
   logic       reset_active_d;
   logic       nmi_pending;
   logic       nmi_clear;
   logic       poll;
   logic       commit;
   logic       irq_req;

   interrupt_sequencer_nmi_edge_detect u_nmi_edge_detect (
      .clk_i     (i_clk),
      .reset_n_i (i_reset_n),
      .nmi_n_i   (i_nmi_n),
      .clear_i   (nmi_clear),
      .pending_o (nmi_pending)
   );

   assign poll    = (i_tcu_next == TCU_FETCH);
   // A poll on the same edge owns the decision; the commit point is ignored.
   assign commit  = i_vector_cycle & ~poll;
   assign irq_req = ~i_irq_n & ~i_flag_i;

   // State register
   always_ff @(negedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q        <= ST_SEQ_RESET;
         vector_q       <= VECTOR_SEL_RESET;
         int_active_q   <= 1'b1;
         reset_active_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         vector_q       <= vector_d;
         int_active_q   <= int_active_d;
         reset_active_q <= reset_active_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      vector_d  = vector_q;
      nmi_clear = 1'b0;
      if (poll) begin
         // Any state may chain straight into the next sequence here.
         if (nmi_pending) begin
            state_d   = ST_SEQ_NMI;
            vector_d  = VECTOR_SEL_NMI;
            nmi_clear = 1'b1;
         end else if (irq_req) begin
            state_d  = ST_SEQ_IRQ;
            vector_d = VECTOR_SEL_IRQ;
         end else begin
            state_d  = ST_IDLE;
            vector_d = VECTOR_SEL_IRQ;
         end
      end else if (commit && nmi_pending &&
                   (state_q == ST_SEQ_IRQ || state_q == ST_IDLE)) begin
         // NMI hijacks an IRQ entry, or a software BRK running in IDLE.
         vector_d  = VECTOR_SEL_NMI;
         nmi_clear = 1'b1;
         if (state_q == ST_SEQ_IRQ) begin
            state_d = ST_SEQ_NMI;
         end
      end
   end

   // Output logic
   always_comb begin
      o_force_brk    = poll & (nmi_pending | irq_req);
      int_active_d   = (state_d != ST_IDLE);
      reset_active_d = (state_d == ST_SEQ_RESET);
   end

   assign o_int_active   = int_active_q;
   assign o_reset_active = reset_active_q;
   assign o_vector_sel   = vector_q;
   assign o_nmi_pending  = nmi_pending;

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

   logic       i_clk = 1'b1;
   logic       i_reset_n;
   logic       i_nmi_n;
   logic       i_irq_n;
   logic       i_flag_i;
   logic [3:0] i_tcu_next;
   logic       i_vector_cycle;
   logic       o_force_brk;
   logic       o_int_active;
   logic       o_reset_active;
   logic [1:0] o_vector_sel;
   logic       o_nmi_pending;

   int checks = 0;
   int errors = 0;

   interrupt_sequencer dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_nmi_n        (i_nmi_n),
      .i_irq_n        (i_irq_n),
      .i_flag_i       (i_flag_i),
      .i_tcu_next     (i_tcu_next),
      .i_vector_cycle (i_vector_cycle),
      .o_force_brk    (o_force_brk),
      .o_int_active   (o_int_active),
      .o_reset_active (o_reset_active),
      .o_vector_sel   (o_vector_sel),
      .o_nmi_pending  (o_nmi_pending)
   );

   always #5 i_clk = ~i_clk;

   // Advance past the next active (falling) edge and settle.
   task automatic tick();
      @(negedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (o_int_active !== 1'b1) begin errors++; $display("FAIL rst_int_active got %b exp 1", o_int_active); end
      checks++; if (o_reset_active !== 1'b1) begin errors++; $display("FAIL rst_reset_active got %b exp 1", o_reset_active); end
      checks++; if (o_vector_sel !== 2'b10) begin errors++; $display("FAIL rst_vector got %b exp 10", o_vector_sel); end
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL rst_nmi_pending got %b exp 0", o_nmi_pending); end
      i_reset_n = 1'b1;
      tick();
      tick();
      checks++; if (o_reset_active !== 1'b1) begin errors++; $display("FAIL rst_hold_active got %b exp 1", o_reset_active); end
      checks++; if (o_vector_sel !== 2'b10) begin errors++; $display("FAIL rst_hold_vector got %b exp 10", o_vector_sel); end
      i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b0) begin errors++; $display("FAIL rst_poll_force_brk got %b exp 0", o_force_brk); end
      tick();
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL rst_end_int_active got %b exp 0", o_int_active); end
      checks++; if (o_reset_active !== 1'b0) begin errors++; $display("FAIL rst_end_reset_active got %b exp 0", o_reset_active); end
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL rst_end_vector got %b exp 00", o_vector_sel); end
      i_tcu_next = 4'd2;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_irq();
      i_irq_n = 1'b0; i_flag_i = 1'b0; i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b1) begin errors++; $display("FAIL irq_force_brk got %b exp 1", o_force_brk); end
      tick();
      checks++; if (o_int_active !== 1'b1) begin errors++; $display("FAIL irq_int_active got %b exp 1", o_int_active); end
      checks++; if (o_reset_active !== 1'b0) begin errors++; $display("FAIL irq_reset_active got %b exp 0", o_reset_active); end
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL irq_vector got %b exp 00", o_vector_sel); end
      i_irq_n = 1'b1; i_flag_i = 1'b1; i_tcu_next = 4'd2;
      tick();
      i_tcu_next = 4'd1;
      tick();
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL irq_end_int_active got %b exp 0", o_int_active); end
      // Masked IRQ must not be taken.
      i_irq_n = 1'b0; i_flag_i = 1'b1; i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b0) begin errors++; $display("FAIL irq_masked_force_brk got %b exp 0", o_force_brk); end
      tick();
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL irq_masked_int_active got %b exp 0", o_int_active); end
      i_irq_n = 1'b1; i_tcu_next = 4'd2;
      tick();
      $display("test_irq done");
   endtask

   task automatic test_nmi_priority();
      i_irq_n = 1'b0; i_flag_i = 1'b0; i_nmi_n = 1'b0; i_tcu_next = 4'd2;
      tick();
      checks++; if (o_nmi_pending !== 1'b1) begin errors++; $display("FAIL prio_pending_set got %b exp 1", o_nmi_pending); end
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL prio_idle got %b exp 0", o_int_active); end
      i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b1) begin errors++; $display("FAIL prio_force_brk got %b exp 1", o_force_brk); end
      tick();
      checks++; if (o_vector_sel !== 2'b01) begin errors++; $display("FAIL prio_nmi_vector got %b exp 01", o_vector_sel); end
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL prio_pending_clear got %b exp 0", o_nmi_pending); end
      checks++; if (o_int_active !== 1'b1) begin errors++; $display("FAIL prio_nmi_active got %b exp 1", o_int_active); end
      i_tcu_next = 4'd2;
      tick();
      i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b1) begin errors++; $display("FAIL prio_chain_force_brk got %b exp 1", o_force_brk); end
      tick();
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL prio_chain_vector got %b exp 00", o_vector_sel); end
      checks++; if (o_int_active !== 1'b1) begin errors++; $display("FAIL prio_chain_active got %b exp 1", o_int_active); end
      i_irq_n = 1'b1; i_flag_i = 1'b1; i_nmi_n = 1'b1; i_tcu_next = 4'd2;
      tick();
      i_tcu_next = 4'd1;
      tick();
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL prio_end_active got %b exp 0", o_int_active); end
      i_tcu_next = 4'd2;
      tick();
      $display("test_nmi_priority done");
   endtask

   task automatic test_nmi_latency();
      // Edge and poll on the same clock: not taken yet.
      i_nmi_n = 1'b0; i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b0) begin errors++; $display("FAIL lat_same_edge got %b exp 0", o_force_brk); end
      tick();
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL lat_idle got %b exp 0", o_int_active); end
      checks++; if (o_nmi_pending !== 1'b1) begin errors++; $display("FAIL lat_pending got %b exp 1", o_nmi_pending); end
      i_nmi_n = 1'b1; i_tcu_next = 4'd2;
      tick();
      // Service and a fresh edge on the same clock: pending stays set.
      i_nmi_n = 1'b0; i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b1) begin errors++; $display("FAIL lat_take got %b exp 1", o_force_brk); end
      tick();
      checks++; if (o_nmi_pending !== 1'b1) begin errors++; $display("FAIL lat_set_wins got %b exp 1", o_nmi_pending); end
      checks++; if (o_vector_sel !== 2'b01) begin errors++; $display("FAIL lat_vector got %b exp 01", o_vector_sel); end
      i_tcu_next = 4'd2;
      tick();
      i_tcu_next = 4'd1;
      tick();
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL lat_second_clear got %b exp 0", o_nmi_pending); end
      i_nmi_n = 1'b1; i_tcu_next = 4'd2;
      tick();
      i_tcu_next = 4'd1;
      tick();
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL lat_end_vector got %b exp 00", o_vector_sel); end
      i_tcu_next = 4'd2;
      tick();
      $display("test_nmi_latency done");
   endtask

   task automatic test_hijack();
      i_irq_n = 1'b0; i_flag_i = 1'b0; i_tcu_next = 4'd1;
      tick();
      i_irq_n = 1'b1; i_flag_i = 1'b1; i_tcu_next = 4'd2; i_nmi_n = 1'b0;
      tick();
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL hij_pre_vector got %b exp 00", o_vector_sel); end
      checks++; if (o_nmi_pending !== 1'b1) begin errors++; $display("FAIL hij_pre_pending got %b exp 1", o_nmi_pending); end
      i_vector_cycle = 1'b1;
      tick();
      checks++; if (o_vector_sel !== 2'b01) begin errors++; $display("FAIL hij_vector got %b exp 01", o_vector_sel); end
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL hij_pending got %b exp 0", o_nmi_pending); end
      checks++; if (o_int_active !== 1'b1) begin errors++; $display("FAIL hij_active got %b exp 1", o_int_active); end
      i_vector_cycle = 1'b0;
      tick();
      checks++; if (o_vector_sel !== 2'b01) begin errors++; $display("FAIL hij_vector_stable got %b exp 01", o_vector_sel); end
      i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b0) begin errors++; $display("FAIL hij_no_extra got %b exp 0", o_force_brk); end
      tick();
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL hij_end_vector got %b exp 00", o_vector_sel); end
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL hij_end_active got %b exp 0", o_int_active); end
      i_tcu_next = 4'd2; i_nmi_n = 1'b1;
      tick();
      // Software BRK in IDLE hijacked by NMI.
      i_nmi_n = 1'b0;
      tick();
      i_vector_cycle = 1'b1;
      tick();
      checks++; if (o_vector_sel !== 2'b01) begin errors++; $display("FAIL brk_vector got %b exp 01", o_vector_sel); end
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL brk_pending got %b exp 0", o_nmi_pending); end
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL brk_active got %b exp 0", o_int_active); end
      i_vector_cycle = 1'b0; i_tcu_next = 4'd1;
      tick();
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL brk_end_vector got %b exp 00", o_vector_sel); end
      i_tcu_next = 4'd2; i_nmi_n = 1'b1;
      tick();
      $display("test_hijack done");
   endtask

   task automatic test_nmi_held_low();
      int taken = 0;
      i_nmi_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         i_tcu_next = ((i % 4) == 3) ? 4'd1 : 4'd2;
         #1;
         if (o_force_brk === 1'b1) taken++;
         tick();
      end
      checks++; if (taken !== 1) begin errors++; $display("FAIL held_low_count got %0d exp 1", taken); end
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL held_low_pending got %b exp 0", o_nmi_pending); end
      checks++; if (o_int_active !== 1'b0) begin errors++; $display("FAIL held_low_active got %b exp 0", o_int_active); end
      i_nmi_n = 1'b1; i_tcu_next = 4'd2;
      tick();
      $display("test_nmi_held_low done");
   endtask

   task automatic test_reset_mid_nmi();
      i_nmi_n = 1'b0;
      tick();
      i_tcu_next = 4'd1;
      tick();
      checks++; if (o_vector_sel !== 2'b01) begin errors++; $display("FAIL rmid_nmi_vector got %b exp 01", o_vector_sel); end
      i_tcu_next = 4'd2; i_nmi_n = 1'b1;
      tick();
      i_nmi_n = 1'b0;
      tick();
      checks++; if (o_nmi_pending !== 1'b1) begin errors++; $display("FAIL rmid_pending got %b exp 1", o_nmi_pending); end
      #2;
      i_reset_n = 1'b0;
      #1;
      checks++; if (o_reset_active !== 1'b1) begin errors++; $display("FAIL rmid_reset_active got %b exp 1", o_reset_active); end
      checks++; if (o_int_active !== 1'b1) begin errors++; $display("FAIL rmid_int_active got %b exp 1", o_int_active); end
      checks++; if (o_vector_sel !== 2'b10) begin errors++; $display("FAIL rmid_vector got %b exp 10", o_vector_sel); end
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL rmid_pending_lost got %b exp 0", o_nmi_pending); end
      #1;
      i_reset_n = 1'b1;
      tick();
      tick();
      // NMI held low across reset must not register as an edge.
      checks++; if (o_nmi_pending !== 1'b0) begin errors++; $display("FAIL rmid_held_pending got %b exp 0", o_nmi_pending); end
      i_tcu_next = 4'd1;
      #1;
      checks++; if (o_force_brk !== 1'b0) begin errors++; $display("FAIL rmid_poll_force_brk got %b exp 0", o_force_brk); end
      tick();
      checks++; if (o_reset_active !== 1'b0) begin errors++; $display("FAIL rmid_end_reset got %b exp 0", o_reset_active); end
      checks++; if (o_vector_sel !== 2'b00) begin errors++; $display("FAIL rmid_end_vector got %b exp 00", o_vector_sel); end
      i_nmi_n = 1'b1; i_tcu_next = 4'd2;
      tick();
      $display("test_reset_mid_nmi done");
   endtask

   initial begin
      i_reset_n      = 1'b0;
      i_nmi_n        = 1'b1;
      i_irq_n        = 1'b1;
      i_flag_i       = 1'b1;
      i_tcu_next     = 4'd2;
      i_vector_cycle = 1'b0;
      tick();
      tick();
      test_reset();
      test_irq();
      test_nmi_priority();
      test_nmi_latency();
      test_hijack();
      test_nmi_held_low();
      test_reset_mid_nmi();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
